// File: rtl/legv8_pkg.sv
// Shared opcode constants and decode/FSM types for the LEGv8 multicycle controller.
package legv8_pkg;

  localparam logic [10:0] OP_LSL  = 11'h69B;
  localparam logic [10:0] OP_LSR  = 11'h69A;
  localparam logic [10:0] OP_MUL  = 11'h4D8;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [4:0]  COND_LT = 5'h0B;

  typedef enum logic [2:0] {
    IMM_SHAMT = 3'd0,
    IMM_D     = 3'd1,
    IMM_CB    = 3'd2,
    IMM_B     = 3'd3,
    IMM_I     = 3'd4,
    IMM_NONE  = 3'd7
  } imm_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_LSL   = 3'd2,
    ALU_LSR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_MUL = 2'd2
  } wb_sel_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_SHIFT, CL_FLAG, CL_MUL, CL_LOAD,
    CL_STORE, CL_ADDI, CL_CBZ, CL_BLT, CL_B
  } instr_class_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MULW, S_MEM, S_WB, S_HALT
  } state_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Handshake bundle between the controller and instruction memory, data memory and multiplier.
interface legv8_multicycle_ctrl_if;
  // Requests (imem_req, dmem_rd, dmem_wr) stay high until the matching ready is seen high in the
  // same cycle; that cycle completes the transfer. mul_start is a one-cycle pulse, mul_done a level.
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        dmem_ready;
  logic        mul_start;
  logic        mul_done;

  modport master (
    input  instr, imem_ready, dmem_ready, mul_done,
    output imem_req, dmem_rd, dmem_wr, mul_start
  );

  modport slave (
    output instr, imem_ready, dmem_ready, mul_done,
    input  imem_req, dmem_rd, dmem_wr, mul_start
  );
endinterface

// File: rtl/legv8_decode.sv
// Combinational instruction classifier: opcode -> class, immediate format and ALU operation.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output imm_sel_t     imm,
  output alu_op_t      alu,
  output logic         valid
);

  // Register and immediate fields belong to the datapath.
  logic unused_bits;
  assign unused_bits = ^instr[20:5];

  always_comb begin
    cls = CL_NONE;
    imm = IMM_NONE;
    alu = ALU_ADD;
    if (instr[31:21] == OP_LSL) begin
      cls = CL_SHIFT; imm = IMM_SHAMT; alu = ALU_LSL;
    end else if (instr[31:21] == OP_LSR) begin
      cls = CL_SHIFT; imm = IMM_SHAMT; alu = ALU_LSR;
    end else if (instr[31:21] == OP_MUL) begin
      cls = CL_MUL;
    end else if (instr[31:21] == OP_ADDS) begin
      cls = CL_FLAG;
    end else if (instr[31:21] == OP_SUBS) begin
      cls = CL_FLAG; alu = ALU_SUB;
    end else if (instr[31:21] == OP_LDUR) begin
      cls = CL_LOAD; imm = IMM_D;
    end else if (instr[31:21] == OP_STUR) begin
      cls = CL_STORE; imm = IMM_D;
    end else if (instr[31:22] == OP_ADDI) begin
      cls = CL_ADDI; imm = IMM_I;
    end else if (instr[31:24] == OP_CBZ) begin
      cls = CL_CBZ; imm = IMM_CB; alu = ALU_PASSB;
    end else if (instr[31:24] == OP_BCOND && instr[4:0] == COND_LT) begin
      cls = CL_BLT; imm = IMM_CB;
    end else if (instr[31:26] == OP_B) begin
      cls = CL_B; imm = IMM_B;
    end
    valid = (cls != CL_NONE);
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control FSM: sequences fetch/decode/execute/memory/writeback and counts retires.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  legv8_multicycle_ctrl_if.master bus,
  output logic             ir_we,
  output logic [2:0]       imm_sel,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             flag_we,
  input  logic             alu_zero,
  input  logic             flag_n,
  input  logic             flag_v,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  state_t       state_q;
  instr_class_t cls_q;
  imm_sel_t     imm_q;
  alu_op_t      alu_q;
  logic         illegal_q;
  logic [CNT_W-1:0] retired_q;

  instr_class_t dec_cls;
  imm_sel_t     dec_imm;
  alu_op_t      dec_alu;
  logic         dec_valid;

  legv8_decode u_decode (
    .instr (bus.instr),
    .cls   (dec_cls),
    .imm   (dec_imm),
    .alu   (dec_alu),
    .valid (dec_valid)
  );

  // Decode is captured on the IR load edge, so DECODE only has to act on the latched class.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_NONE;
      imm_q     <= IMM_NONE;
      alu_q     <= ALU_ADD;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (pc_we) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_FETCH: if (bus.imem_ready) begin
          state_q <= S_DECODE;
          cls_q   <= dec_valid ? dec_cls : CL_NONE;
          imm_q   <= dec_imm;
          alu_q   <= dec_alu;
        end
        S_DECODE: if (cls_q == CL_NONE) begin
          state_q   <= S_HALT;
          illegal_q <= 1'b1;
        end else begin
          state_q <= S_EXEC;
        end
        S_EXEC: case (cls_q)
          CL_MUL:                 state_q <= S_MULW;
          CL_LOAD, CL_STORE:      state_q <= S_MEM;
          CL_B, CL_CBZ, CL_BLT:   state_q <= S_FETCH;
          default:                state_q <= S_WB;
        endcase
        S_MULW: if (bus.mul_done) state_q <= S_WB;
        S_MEM: if (bus.dmem_ready) state_q <= (cls_q == CL_LOAD) ? S_WB : S_FETCH;
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_rd   = 1'b0;
    bus.dmem_wr   = 1'b0;
    bus.mul_start = 1'b0;
    ir_we         = 1'b0;
    alu_src_imm   = 1'b0;
    flag_we       = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        ir_we        = bus.imem_ready;
      end
      S_EXEC: begin
        alu_src_imm   = (cls_q inside {CL_SHIFT, CL_ADDI, CL_LOAD, CL_STORE});
        flag_we       = (cls_q == CL_FLAG);
        bus.mul_start = (cls_q == CL_MUL);
        case (cls_q)
          CL_B:    begin pc_we = 1'b1; pc_sel = 1'b1; end
          CL_CBZ:  begin pc_we = 1'b1; pc_sel = alu_zero; end
          CL_BLT:  begin pc_we = 1'b1; pc_sel = flag_n ^ flag_v; end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.dmem_rd = (cls_q == CL_LOAD);
        bus.dmem_wr = (cls_q == CL_STORE);
        pc_we       = (cls_q == CL_STORE) && bus.dmem_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        wb_sel = (cls_q == CL_LOAD) ? WB_MEM : (cls_q == CL_MUL) ? WB_MUL : WB_ALU;
      end
      default: ;
    endcase
  end

  assign imm_sel   = imm_q;
  assign alu_op    = alu_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule
